route_ctrl: RTL and testbench

ROUTE_CTRL -- requirements
Module: route_ctrl

---
 rtl/route_ctrl.sv | 133 +++++++++++++
 tb/tb_route_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/route_ctrl.sv
// XY-routing packet controller: claims an output port for each head flit and forwards flits until the tail.
// Optional ROUTE_LOOKAHEAD_EN routes the next packet from the lookahead flit so no idle cycle separates packets.
module route_ctrl #(
    parameter int WIDTH   = 16,
    parameter int X_COORD = 0,
    parameter int Y_COORD = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] data_out,
    input  logic             next_data_valid,
    input  logic [WIDTH-1:0] next_data_out,
    output logic             pop_req,
    output logic [4:0]       req,
    input  logic             gnt,
    input  logic             out_ready,
    output logic [WIDTH-1:0] flit_out,
    output logic             flit_valid,
    output logic             drop_err,
    output logic [7:0]       pkt_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    localparam logic [3:0] X_POS = X_COORD[3:0];
    localparam logic [3:0] Y_POS = Y_COORD[3:0];

    // Handshake: a flit moves on a cycle where flit_valid is high (data_valid & out_ready in XFER);
    // pop_req mirrors that transfer, or flags an orphan flit being discarded in IDLE.

    state_t     state_q, state_d;
    logic [4:0] req_q, req_d;
    logic [7:0] cnt_q, cnt_d;
    logic       first_q, first_d;
    logic       pop_c, drop_c;
    logic [1:0] head_type;
    logic       unused_next;

    // Port bits {Local,W,S,E,N} = [4:0]; X is resolved before Y.
    function automatic logic [4:0] route(input logic [WIDTH-1:0] f);
        logic [3:0] dx;
        logic [3:0] dy;
        dx = f[7:4];
        dy = f[3:0];
        if (dx > X_POS)      route = 5'b00010;
        else if (dx < X_POS) route = 5'b01000;
        else if (dy > Y_POS) route = 5'b00100;
        else if (dy < Y_POS) route = 5'b00001;
        else                 route = 5'b10000;
    endfunction

    assign head_type   = data_out[WIDTH-1:WIDTH-2];
    assign unused_next = (^next_data_out) & next_data_valid;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        pop_c      = 1'b0;
        drop_c     = 1'b0;
        flit_valid = 1'b0;
        flit_out   = '0;
        case (state_q)
            S_IDLE: begin
                if (data_valid) begin
                    if (head_type[0]) begin
                        req_d   = route(data_out);
                        state_d = S_REQ;
                    end else begin
                        pop_c  = 1'b1;
                        drop_c = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (gnt) begin
                    state_d = S_XFER;
                    first_d = 1'b1;
                end
            end
            S_XFER: begin
                flit_out   = data_out;
                flit_valid = data_valid & out_ready;
                pop_c      = flit_valid;
                if (flit_valid) begin
                    first_d = 1'b0;
                    // A late head/single is treated as body; only a tail or the opening single ends the packet.
                    if (head_type == 2'b10 || (head_type == 2'b11 && first_q)) begin
                        cnt_d   = cnt_q + 8'd1;
                        req_d   = 5'b00000;
                        state_d = S_IDLE;
`ifdef ROUTE_LOOKAHEAD_EN
                        if (next_data_valid && next_data_out[WIDTH-2]) begin
                            req_d   = route(next_data_out);
                            state_d = S_REQ;
                        end
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Combinational strobes are masked so they drop the instant reset asserts.
    assign pop_req   = pop_c & rst_n;
    assign drop_err  = drop_c & rst_n;
    assign req       = req_q;
    assign pkt_count = cnt_q;
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= 5'b00000;
            cnt_q   <= 8'd0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_route_ctrl.sv
// Directed bench for route_ctrl at router (1,1): input-buffer model, auto-grant, flit scoreboard.
module tb_route_ctrl;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         data_valid;
    logic [W-1:0] data_out;
    logic         next_data_valid;
    logic [W-1:0] next_data_out;
    logic         pop_req;
    logic [4:0]   req;
    logic         gnt;
    logic         out_ready;
    logic [W-1:0] flit_out;
    logic         flit_valid;
    logic         drop_err;
    logic [7:0]   pkt_count;
    logic [1:0]   state_dbg;

    logic [W-1:0] buf_q[$];
    logic [W-1:0] exp_q[$];
    logic         pop_pending;
    int           checks;
    int           failures;

    route_ctrl #(.WIDTH(W), .X_COORD(1), .Y_COORD(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_valid(data_valid), .data_out(data_out),
        .next_data_valid(next_data_valid), .next_data_out(next_data_out),
        .pop_req(pop_req), .req(req), .gnt(gnt), .out_ready(out_ready),
        .flit_out(flit_out), .flit_valid(flit_valid), .drop_err(drop_err),
        .pkt_count(pkt_count), .state_dbg(state_dbg)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Input buffer model: pops on the edge after pop_req was seen, updates just after the edge.
    initial begin
        pop_pending = 1'b0;
        forever begin
            @(negedge clk);
            pop_pending = pop_req;
        end
    end

    initial begin
        data_valid = 1'b0; data_out = '0;
        next_data_valid = 1'b0; next_data_out = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pop_pending && buf_q.size() > 0) void'(buf_q.pop_front());
            data_valid = 1'b0; data_out = '0;
            next_data_valid = 1'b0; next_data_out = '0;
            if (buf_q.size() > 0) begin
                data_valid = 1'b1;
                data_out   = buf_q[0];
            end
            if (buf_q.size() > 1) begin
                next_data_valid = 1'b1;
                next_data_out   = buf_q[1];
            end
        end
    end

    // Arbiter model: grants one cycle after a request is seen.
    initial begin
        logic gs;
        gnt = 1'b0;
        forever begin
            @(negedge clk);
            gs = (req != 5'b0);
            @(posedge clk);
            #1 gnt = gs;
        end
    end

    // Scoreboard monitor
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && flit_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_flit actual=0x%0h expected=none at %0t", flit_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("flit_data", 32'(flit_out), 32'(e));
                end
            end
        end
    end

    // Driver tasks (called at a negedge)
    task automatic load(input logic [W-1:0] f, input bit expect_fwd);
        buf_q.push_back(f);
        if (expect_fwd) exp_q.push_back(f);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_req(input logic [4:0] e, input string name);
        int n = 0;
        while (req !== e && n < 50) begin tick(); n++; end
        chk(name, 32'(req), 32'(e));
    endtask

    task automatic wait_fv(input string name);
        int n = 0;
        while (flit_valid !== 1'b1 && n < 50) begin tick(); n++; end
        chk(name, 32'(flit_valid), 32'd1);
    endtask

    task automatic wait_flit(input logic [W-1:0] v, input string name);
        int n = 0;
        while (!(flit_valid === 1'b1 && flit_out === v) && n < 50) begin tick(); n++; end
        chk(name, 32'(flit_valid === 1'b1 && flit_out === v), 32'd1);
    endtask

    task automatic wait_pkt(input logic [7:0] v, input string name);
        int n = 0;
        while (pkt_count !== v && n < 60) begin tick(); n++; end
        chk(name, 32'(pkt_count), 32'(v));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        out_ready = 1'b1;
        #3;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_pop", 32'(pop_req), 32'd0);
        chk("rst_fv", 32'(flit_valid), 32'd0);
        chk("rst_flit", 32'(flit_out), 32'd0);
        chk("rst_drop", 32'(drop_err), 32'd0);
        chk("rst_cnt", 32'(pkt_count), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // Head to (3,0) goes East, four flits back to back
        load(16'h4030, 1); load(16'h0011, 1); load(16'h0022, 1); load(16'h8033, 1);
        wait_req(5'b00010, "t1_req_east");
        wait_fv("t1_first_flit");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_consec_%0d", i), 32'(flit_valid), 32'd1);
            tick();
        end
        chk("t1_req_clear", 32'(req), 32'd0);
        chk("t1_pkt", 32'(pkt_count), 32'd1);

        // Single flit to own coordinates goes Local
        load(16'hC011, 1);
        wait_req(5'b10000, "t2_req_local");
        wait_fv("t2_flit");
        tick();
        chk("t2_req_clear", 32'(req), 32'd0);
        chk("t2_pkt", 32'(pkt_count), 32'd2);

        // Orphan body flit in IDLE is dropped
        load(16'h0005, 0);
        tick();
        chk("t3_pop", 32'(pop_req), 32'd1);
        chk("t3_drop", 32'(drop_err), 32'd1);
        chk("t3_req", 32'(req), 32'd0);
        chk("t3_fv", 32'(flit_valid), 32'd0);
        tick();
        chk("t3_drop_pulse", 32'(drop_err), 32'd0);

        // Backpressure: out_ready 1,0,0,1
        load(16'h4020, 1); load(16'h0101, 1); load(16'h0102, 1); load(16'h8103, 1);
        wait_fv("t4_first_flit");
        @(posedge clk); #1 out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("t4_stall_fv_%0d", i), 32'(flit_valid), 32'd0);
            chk($sformatf("t4_stall_pop_%0d", i), 32'(pop_req), 32'd0);
            chk($sformatf("t4_stall_req_%0d", i), 32'(req), 32'b00010);
            if (i == 0) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_pkt(8'd3, "t4_pkt");

        // Tail followed by a head to (1,0) sitting in lookahead
        load(16'h4030, 1); load(16'h8044, 1); load(16'h4010, 1); load(16'h8055, 1);
        wait_flit(16'h8044, "t5_tail_seen");
        tick();
`ifdef ROUTE_LOOKAHEAD_EN
        chk("t5_req_zero_bubble", 32'(req), 32'b00001);
`else
        chk("t5_bubble_req", 32'(req), 32'd0);
        chk("t5_bubble_state", 32'(state_dbg), 32'd0);
        tick();
        chk("t5_req_after_bubble", 32'(req), 32'b00001);
`endif
        wait_pkt(8'd5, "t5_pkt");

        // Reset in the middle of a packet
        load(16'h4030, 1); load(16'h0011, 1); load(16'h0022, 0); load(16'h8033, 0);
        wait_flit(16'h0011, "t6_second_flit");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_req", 32'(req), 32'd0);
        chk("t6_pop", 32'(pop_req), 32'd0);
        chk("t6_fv", 32'(flit_valid), 32'd0);
        chk("t6_flit", 32'(flit_out), 32'd0);
        chk("t6_drop", 32'(drop_err), 32'd0);
        chk("t6_cnt", 32'(pkt_count), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        chk("t6_idle", 32'(state_dbg), 32'd0);
        chk("t6_body_drop", 32'(drop_err), 32'd1);
        chk("t6_body_pop", 32'(pop_req), 32'd1);
        tick();
        chk("t6_tail_drop", 32'(drop_err), 32'd1);
        tick();
        chk("t6_drop_end", 32'(drop_err), 32'd0);
        chk("t6_req_end", 32'(req), 32'd0);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
